// File: rtl/salsa_state_feed.sv
// Salsa20 input-matrix feeder: streams 16 words per start, then bumps the block counter.
// First word 1 cycle after start; words hold stable while take is low, config is frozen while busy.
module salsa_state_feed #(
  parameter int unsigned KEY128 = 0,
  parameter int unsigned CTR_W  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        start,
  input  logic        take,
  output logic        valid,
  output logic [31:0] data_out,
  output logic [3:0]  word_idx,
  output logic        busy,
  output logic        done,
  output logic        ctr_wrap
);

  localparam logic [31:0] C0      = 32'h61707865;
  localparam logic [31:0] C1_256  = 32'h3320646e;
  localparam logic [31:0] C1_128  = 32'h3120646e;
  localparam logic [31:0] C2_256  = 32'h79622d32;
  localparam logic [31:0] C2_128  = 32'h79622d36;
  localparam logic [31:0] C3      = 32'h6b206574;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [31:0]        key   [8];
  logic [31:0]        nonce [2];
  logic [CTR_W-1:0]   ctr;
  logic               cfg_ok;

  assign cfg_ok = cfg_we && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) key[i] <= '0;
      nonce[0] <= '0;
      nonce[1] <= '0;
    end else if (cfg_ok) begin
      if (!cfg_addr[3])
        key[cfg_addr[2:0]] <= cfg_data;
      else if (cfg_addr[3:1] == 3'b100)
        nonce[cfg_addr[0]] <= cfg_data;
    end
  end

  // Counter lives in the FSM block: it is written by config in IDLE and
  // incremented on the final accept, never both in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_idx <= '0;
      ctr      <= '0;
      ctr_wrap <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we && cfg_addr[3:1] == 3'b101) begin
            if (cfg_addr[0])
              ctr[CTR_W-1:32] <= cfg_data;
            else
              ctr[31:0] <= cfg_data;
            ctr_wrap <= 1'b0;
          end
          if (start) begin
            state    <= SEND;
            busy     <= 1'b1;
            valid    <= 1'b1;
            word_idx <= '0;
          end
        end
        SEND: begin
          if (take) begin
            if (word_idx == 4'd15) begin
              state    <= IDLE;
              busy     <= 1'b0;
              valid    <= 1'b0;
              word_idx <= '0;
              done     <= 1'b1;
              ctr      <= ctr + {{(CTR_W-1){1'b0}}, 1'b1};
              if (&ctr) ctr_wrap <= 1'b1;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    data_out = C0;
    case (word_idx)
      4'd0:  data_out = C0;
      4'd1:  data_out = key[0];
      4'd2:  data_out = key[1];
      4'd3:  data_out = key[2];
      4'd4:  data_out = key[3];
      4'd5:  data_out = (KEY128 != 0) ? C1_128 : C1_256;
      4'd6:  data_out = nonce[0];
      4'd7:  data_out = nonce[1];
      4'd8:  data_out = ctr[31:0];
      4'd9:  data_out = ctr[CTR_W-1:32];
      4'd10: data_out = (KEY128 != 0) ? C2_128 : C2_256;
      4'd11: data_out = (KEY128 != 0) ? key[0] : key[4];
      4'd12: data_out = (KEY128 != 0) ? key[1] : key[5];
      4'd13: data_out = (KEY128 != 0) ? key[2] : key[6];
      4'd14: data_out = (KEY128 != 0) ? key[3] : key[7];
      4'd15: data_out = C3;
    endcase
  end

endmodule
